commit_trace_checker: RTL and testbench

In-order commit-stream comparator for the lockstep correctness harness that pairs the ridecore out-of-order core with the single-cycle ISA model. It buffers retirement records from both machines in separate FIFOs, which absorbs the OoO core's burst of up to two commits per cycle against the ISA model's one per cycle. It pops one record from each FIFO per cycle and compares PC and register writeback, raising a sticky verdict with the failing commit index. It provides stall requests back to both producers and replaces end-state register-file comparison with per-commit checking.

---
 rtl/commit_trace_checker.sv | 189 ++++++++++++++++++
 tb/tb_commit_trace_checker.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_checker.sv
// Lockstep commit-stream comparator: buffers OoO (2-wide) and ISA (1-wide) retirement
// records, compares them pairwise in order and latches the first divergence.
module commit_trace_checker #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ooo_com_valid,
    input  logic [31:0] ooo_com_pc0,
    input  logic [31:0] ooo_com_pc1,
    input  logic        ooo_com_we0,
    input  logic        ooo_com_we1,
    input  logic [4:0]  ooo_com_rd0,
    input  logic [4:0]  ooo_com_rd1,
    input  logic [31:0] ooo_com_data0,
    input  logic [31:0] ooo_com_data1,
    input  logic        ooo_flush,
    input  logic        isa_com_valid,
    input  logic [31:0] isa_com_pc,
    input  logic        isa_com_we,
    input  logic [4:0]  isa_com_rd,
    input  logic [31:0] isa_com_data,
    output logic        ooo_stall,
    output logic        isa_stall,
    output logic        mismatch,
    output logic [1:0]  mismatch_kind,
    output logic [31:0] mismatch_index,
    output logic [31:0] compared_count,
    output logic        timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [15:0]   TIMEOUT_C = 16'(TIMEOUT);

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } rec_t;

    typedef enum logic [1:0] {
        KIND_NONE  = 2'b00,
        KIND_PC    = 2'b01,
        KIND_WB    = 2'b10,
        KIND_PROTO = 2'b11
    } kind_e;

    // NOTE: the record storage is deliberately not reset; occupancy counters alone
    // decide which entries are live, so stale contents are never observed.
    rec_t ooo_mem [DEPTH];
    rec_t isa_mem [DEPTH];

    logic [AW-1:0] ooo_wr_ptr_q, ooo_wr_ptr_d, ooo_rd_ptr_q, ooo_rd_ptr_d;
    logic [AW-1:0] isa_wr_ptr_q, isa_wr_ptr_d, isa_rd_ptr_q, isa_rd_ptr_d;
    logic [CW-1:0] ooo_count_q, ooo_count_d, isa_count_q, isa_count_d;
    logic          mismatch_q, mismatch_d;
    kind_e         kind_q, kind_d;
    logic [31:0]   index_q, index_d;
    logic [31:0]   cmp_count_q, cmp_count_d;
    logic [15:0]   progress_q, progress_d;
    logic          timeout_q, timeout_d;

    rec_t          ooo_rec0, ooo_rec1, isa_rec, ooo_head, isa_head;
    logic [CW-1:0] ooo_free, ooo_enq_n;
    logic          proto_err, ooo_wr0, ooo_wr1, isa_wr;
    logic          compare, pc_diff, wb_diff;

    // Stalls depend only on registered state, never on the producers' inputs.
    assign ooo_free  = DEPTH_C - ooo_count_q;
    assign ooo_stall = (ooo_free < CW'(2)) || mismatch_q;
    assign isa_stall = (isa_count_q == DEPTH_C) || mismatch_q;

    always_comb begin
        ooo_rec0 = {ooo_com_pc0, ooo_com_we0, ooo_com_rd0, ooo_com_data0};
        ooo_rec1 = {ooo_com_pc1, ooo_com_we1, ooo_com_rd1, ooo_com_data1};
        isa_rec  = {isa_com_pc, isa_com_we, isa_com_rd, isa_com_data};
        ooo_head = ooo_mem[ooo_rd_ptr_q];
        isa_head = isa_mem[isa_rd_ptr_q];
    end

    always_comb begin
        proto_err = ((ooo_com_valid == 2'b10) && !ooo_flush)
                 || ((|ooo_com_valid) && ooo_stall)
                 || (isa_com_valid && isa_stall);
        ooo_wr0   = !proto_err && !ooo_flush && ooo_com_valid[0];
        ooo_wr1   = !proto_err && !ooo_flush && ooo_com_valid[1];
        isa_wr    = !proto_err && isa_com_valid;
        ooo_enq_n = CW'(ooo_wr0) + CW'(ooo_wr1);

        compare = (ooo_count_q != '0) && (isa_count_q != '0) && !mismatch_q;
        pc_diff = ooo_head.pc != isa_head.pc;
        // rd = 0 writes are architecturally discarded, so their data is not compared.
        wb_diff = (ooo_head.we != isa_head.we)
               || (ooo_head.we && ((ooo_head.rd != isa_head.rd)
                                || ((ooo_head.rd != 5'd0) && (ooo_head.data != isa_head.data))));
    end

    always_comb begin
        ooo_wr_ptr_d = ooo_wr_ptr_q + AW'(ooo_enq_n);
        ooo_rd_ptr_d = ooo_rd_ptr_q + AW'(compare);
        ooo_count_d  = ooo_count_q + ooo_enq_n - CW'(compare);
        isa_wr_ptr_d = isa_wr_ptr_q + AW'(isa_wr);
        isa_rd_ptr_d = isa_rd_ptr_q + AW'(compare);
        isa_count_d  = isa_count_q + CW'(isa_wr) - CW'(compare);

        mismatch_d  = mismatch_q;
        kind_d      = kind_q;
        index_d     = index_q;
        cmp_count_d = cmp_count_q;
        progress_d  = progress_q;
        timeout_d   = timeout_q;

        if (!mismatch_q) begin
            if (proto_err) begin
                mismatch_d = 1'b1;
                kind_d     = KIND_PROTO;
                index_d    = cmp_count_q;
            end else if (compare && pc_diff) begin
                mismatch_d = 1'b1;
                kind_d     = KIND_PC;
                index_d    = cmp_count_q;
            end else if (compare && wb_diff) begin
                mismatch_d = 1'b1;
                kind_d     = KIND_WB;
                index_d    = cmp_count_q;
            end

            if (compare && !pc_diff && !wb_diff) begin
                cmp_count_d = cmp_count_q + 32'd1;
            end

            if (compare || ((ooo_count_q == '0) && (isa_count_q == '0))) begin
                progress_d = 16'd0;
            end else if (progress_q != TIMEOUT_C) begin
                progress_d = progress_q + 16'd1;
            end
            timeout_d = timeout_q || (progress_d == TIMEOUT_C);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values computed from the previous cycle's state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ooo_wr_ptr_q <= '0;
            ooo_rd_ptr_q <= '0;
            ooo_count_q  <= '0;
            isa_wr_ptr_q <= '0;
            isa_rd_ptr_q <= '0;
            isa_count_q  <= '0;
            mismatch_q   <= 1'b0;
            kind_q       <= KIND_NONE;
            index_q      <= '0;
            cmp_count_q  <= '0;
            progress_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            ooo_wr_ptr_q <= ooo_wr_ptr_d;
            ooo_rd_ptr_q <= ooo_rd_ptr_d;
            ooo_count_q  <= ooo_count_d;
            isa_wr_ptr_q <= isa_wr_ptr_d;
            isa_rd_ptr_q <= isa_rd_ptr_d;
            isa_count_q  <= isa_count_d;
            mismatch_q   <= mismatch_d;
            kind_q       <= kind_d;
            index_q      <= index_d;
            cmp_count_q  <= cmp_count_d;
            progress_q   <= progress_d;
            timeout_q    <= timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ooo_wr0) ooo_mem[ooo_wr_ptr_q] <= ooo_rec0;
        if (ooo_wr1) ooo_mem[ooo_wr_ptr_q + AW'(1)] <= ooo_rec1;
        if (isa_wr)  isa_mem[isa_wr_ptr_q] <= isa_rec;
    end

    assign mismatch       = mismatch_q;
    assign mismatch_kind  = kind_q;
    assign mismatch_index = index_q;
    assign compared_count = cmp_count_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed scenarios plus randomized lockstep streams checked against a queue-based model.
module tb_commit_trace_checker;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int PN      = 1200;

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ooo_com_valid;
    logic [31:0] ooo_com_pc0, ooo_com_pc1, ooo_com_data0, ooo_com_data1;
    logic        ooo_com_we0, ooo_com_we1;
    logic [4:0]  ooo_com_rd0, ooo_com_rd1;
    logic        ooo_flush;
    logic        isa_com_valid;
    logic [31:0] isa_com_pc, isa_com_data;
    logic        isa_com_we;
    logic [4:0]  isa_com_rd;
    logic        ooo_stall, isa_stall, mismatch, timeout;
    logic [1:0]  mismatch_kind;
    logic [31:0] mismatch_index, compared_count;

    commit_trace_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ooo_com_valid(ooo_com_valid),
        .ooo_com_pc0(ooo_com_pc0), .ooo_com_pc1(ooo_com_pc1),
        .ooo_com_we0(ooo_com_we0), .ooo_com_we1(ooo_com_we1),
        .ooo_com_rd0(ooo_com_rd0), .ooo_com_rd1(ooo_com_rd1),
        .ooo_com_data0(ooo_com_data0), .ooo_com_data1(ooo_com_data1),
        .ooo_flush(ooo_flush),
        .isa_com_valid(isa_com_valid), .isa_com_pc(isa_com_pc),
        .isa_com_we(isa_com_we), .isa_com_rd(isa_com_rd), .isa_com_data(isa_com_data),
        .ooo_stall(ooo_stall), .isa_stall(isa_stall),
        .mismatch(mismatch), .mismatch_kind(mismatch_kind),
        .mismatch_index(mismatch_index), .compared_count(compared_count),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ooo_com_valid = 2'b00;
        ooo_flush     = 1'b0;
        {ooo_com_pc0, ooo_com_we0, ooo_com_rd0, ooo_com_data0} = '0;
        {ooo_com_pc1, ooo_com_we1, ooo_com_rd1, ooo_com_data1} = '0;
        isa_com_valid = 1'b0;
        {isa_com_pc, isa_com_we, isa_com_rd, isa_com_data} = '0;
    endtask

    task automatic drive_ooo(input logic [1:0] v, input logic fl, input rec_t r0, input rec_t r1);
        ooo_com_valid = v;
        ooo_flush     = fl;
        {ooo_com_pc0, ooo_com_we0, ooo_com_rd0, ooo_com_data0} = r0;
        {ooo_com_pc1, ooo_com_we1, ooo_com_rd1, ooo_com_data1} = r1;
    endtask

    task automatic drive_isa(input rec_t r);
        isa_com_valid = 1'b1;
        {isa_com_pc, isa_com_we, isa_com_rd, isa_com_data} = r;
    endtask

    // Reference model: two record queues and the verdict state.
    rec_t        m_ooo[$];
    rec_t        m_isa[$];
    bit          m_mis;
    logic [1:0]  m_kind;
    int unsigned m_index, m_count, m_prog;
    bit          m_timeout;

    function automatic logic [1:0] classify(rec_t o, rec_t i);
        if (o.pc != i.pc) return 2'b01;
        if (o.we != i.we) return 2'b10;
        if (o.we && o.rd != i.rd) return 2'b10;
        if (o.we && o.rd != 5'd0 && o.data != i.data) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit m_ooo_stall();
        return (DEPTH - m_ooo.size() < 2) || m_mis;
    endfunction

    function automatic bit m_isa_stall();
        return (m_isa.size() == DEPTH) || m_mis;
    endfunction

    task automatic model_reset();
        m_ooo.delete();
        m_isa.delete();
        m_mis = 0; m_kind = 2'b00; m_index = 0; m_count = 0; m_prog = 0; m_timeout = 0;
    endtask

    task automatic model_cycle(input logic [1:0] v, input bit fl, input rec_t r0, input rec_t r1,
                               input bit iv, input rec_t ri);
        bit was_mis, both_empty, cmp;
        rec_t a, b;
        logic [1:0] k;
        was_mis    = m_mis;
        both_empty = (m_ooo.size() == 0) && (m_isa.size() == 0);
        cmp        = (m_ooo.size() != 0) && (m_isa.size() != 0) && !m_mis;
        if (cmp) begin
            a = m_ooo.pop_front();
            b = m_isa.pop_front();
            k = classify(a, b);
            if (k == 2'b00) m_count++;
            else begin m_mis = 1; m_kind = k; m_index = m_count; end
        end
        if (!fl && v[0]) m_ooo.push_back(r0);
        if (!fl && v[1]) m_ooo.push_back(r1);
        if (iv) m_isa.push_back(ri);
        if (!was_mis) begin
            if (cmp || both_empty) m_prog = 0;
            else if (m_prog < TIMEOUT) m_prog++;
            if (m_prog == TIMEOUT) m_timeout = 1;
        end
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
    endtask

    function automatic rec_t mk(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                                input logic [31:0] data);
        rec_t r;
        r.pc = pc; r.we = we; r.rd = rd; r.data = data;
        return r;
    endfunction

    rec_t prog [PN];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t r0, r1, ri, z;
        int   n, oi, ii, pct;
        logic [1:0] v;
        bit   fl, iv;

        z = '0;
        rst = 1'b0;
        idle();

        // Reset state.
        do_reset();
        check("rst_ooo_stall", 32'(ooo_stall), 32'd0);
        check("rst_isa_stall", 32'(isa_stall), 32'd0);
        check("rst_mismatch", 32'(mismatch), 32'd0);
        check("rst_kind", 32'(mismatch_kind), 32'd0);
        check("rst_index", mismatch_index, 32'd0);
        check("rst_count", compared_count, 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);

        // Matched stream: OoO dual commit in cycle 1, ISA in cycles 1 and 2.
        do_reset();
        drive_ooo(2'b11, 1'b0, mk(32'h0, 1'b1, 5'd1, 32'd5), mk(32'h4, 1'b1, 5'd2, 32'd7));
        drive_isa(mk(32'h0, 1'b1, 5'd1, 32'd5));
        step();
        idle();
        drive_isa(mk(32'h4, 1'b1, 5'd2, 32'd7));
        step();
        idle();
        check("match_count_c3", compared_count, 32'd1);
        step();
        check("match_count_c4", compared_count, 32'd2);
        check("match_mismatch", 32'(mismatch), 32'd0);

        // Writeback divergence on data.
        do_reset();
        drive_ooo(2'b01, 1'b0, mk(32'h8, 1'b1, 5'd3, 32'h10), z);
        drive_isa(mk(32'h8, 1'b1, 5'd3, 32'h11));
        step();
        idle();
        step();
        check("wb_mismatch", 32'(mismatch), 32'd1);
        check("wb_kind", 32'(mismatch_kind), 32'd2);
        check("wb_index", mismatch_index, 32'd0);
        check("wb_ooo_stall", 32'(ooo_stall), 32'd1);
        check("wb_isa_stall", 32'(isa_stall), 32'd1);
        check("wb_count_frozen", compared_count, 32'd0);

        // rd = 0 data is not compared.
        do_reset();
        drive_ooo(2'b01, 1'b0, mk(32'h20, 1'b1, 5'd0, 32'hAA), z);
        drive_isa(mk(32'h20, 1'b1, 5'd0, 32'h55));
        step();
        idle();
        step();
        check("rd0_count", compared_count, 32'd1);
        check("rd0_mismatch", 32'(mismatch), 32'd0);

        // Backpressure: fill OoO to 6 then 7, then drain one via the ISA stream.
        do_reset();
        for (int i = 0; i < 8; i++) prog[i] = mk(32'(i * 4), 1'b1, 5'(i + 1), 32'(100 + i));
        for (int i = 0; i < 3; i++) begin
            drive_ooo(2'b11, 1'b0, prog[2*i], prog[2*i+1]);
            step();
        end
        idle();
        check("bp_occ6_stall", 32'(ooo_stall), 32'd0);
        drive_ooo(2'b01, 1'b0, prog[6], z);
        step();
        idle();
        check("bp_occ7_stall", 32'(ooo_stall), 32'd1);
        drive_isa(prog[0]);
        step();
        idle();
        check("bp_isa_written_stall", 32'(ooo_stall), 32'd1);
        step();
        check("bp_drain_stall", 32'(ooo_stall), 32'd0);
        check("bp_count", compared_count, 32'd1);
        drive_ooo(2'b01, 1'b0, prog[7], z);
        step();
        check("bp_refill_stall", 32'(ooo_stall), 32'd1);
        drive_ooo(2'b01, 1'b0, prog[0], z);
        step();
        idle();
        check("bp_proto_mismatch", 32'(mismatch), 32'd1);
        check("bp_proto_kind", 32'(mismatch_kind), 32'd3);
        check("bp_proto_index", mismatch_index, 32'd1);

        // Flush suppresses enqueue; 2'b10 is a protocol error.
        do_reset();
        drive_ooo(2'b11, 1'b1, prog[0], prog[1]);
        step();
        for (int i = 0; i < 3; i++) begin
            drive_ooo(2'b11, 1'b0, prog[2*i], prog[2*i+1]);
            step();
        end
        idle();
        check("flush_no_enq_stall", 32'(ooo_stall), 32'd0);
        check("flush_mismatch", 32'(mismatch), 32'd0);
        drive_ooo(2'b10, 1'b0, z, prog[6]);
        step();
        idle();
        check("illegal_mismatch", 32'(mismatch), 32'd1);
        check("illegal_kind", 32'(mismatch_kind), 32'd3);
        check("illegal_index", mismatch_index, 32'd0);

        // Timeout: a lone OoO record with the ISA silent.
        do_reset();
        drive_ooo(2'b01, 1'b0, prog[0], z);
        step();
        idle();
        n = 0;
        while (!timeout && n < 40) begin
            step();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd16);
        check("timeout_flag", 32'(timeout), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check("post_rst_timeout", 32'(timeout), 32'd0);
        check("post_rst_mismatch", 32'(mismatch), 32'd0);
        check("post_rst_kind", 32'(mismatch_kind), 32'd0);
        check("post_rst_index", mismatch_index, 32'd0);
        check("post_rst_count", compared_count, 32'd0);
        check("post_rst_ooo_stall", 32'(ooo_stall), 32'd0);
        check("post_rst_isa_stall", 32'(isa_stall), 32'd0);
        drive_isa(prog[0]);
        step();
        idle();
        step();
        check("rst_discard_count", compared_count, 32'd0);
        check("rst_discard_mismatch", 32'(mismatch), 32'd0);

        // Randomized lockstep streams with occasional ISA-side corruption.
        for (int e = 0; e < 4; e++) begin
            pct = (e == 0) ? 75 : (e == 1) ? 50 : (e == 2) ? 95 : 10;
            for (int i = 0; i < PN; i++) begin
                prog[i].pc   = 32'(i * 4);
                prog[i].we   = ($urandom_range(0, 3) != 0);
                prog[i].rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                prog[i].data = $urandom;
            end
            do_reset();
            oi = 0;
            ii = 0;
            for (int c = 0; c < 500; c++) begin
                check("rnd_ooo_stall", 32'(ooo_stall), 32'(m_ooo_stall()));
                check("rnd_isa_stall", 32'(isa_stall), 32'(m_isa_stall()));
                check("rnd_mismatch", 32'(mismatch), 32'(m_mis));
                check("rnd_kind", 32'(mismatch_kind), 32'(m_kind));
                check("rnd_index", mismatch_index, m_index);
                check("rnd_count", compared_count, m_count);
                check("rnd_timeout", 32'(timeout), 32'(m_timeout));

                idle();
                v = 2'b00; fl = 1'b0; iv = 1'b0;
                r0 = z; r1 = z; ri = z;
                if (!m_ooo_stall() && oi + 2 <= PN) begin
                    n = $urandom_range(0, 7);
                    if (n >= 2 && n <= 4) v = 2'b01;
                    else if (n == 5 || n == 6) v = 2'b11;
                    else if (n == 7) begin
                        fl = 1'b1;
                        v  = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01;
                    end
                    r0 = prog[oi];
                    r1 = prog[oi + 1];
                    drive_ooo(v, fl, r0, r1);
                    if (!fl) oi += (v == 2'b11) ? 2 : (v == 2'b01) ? 1 : 0;
                end
                if (!m_isa_stall() && ii < PN && $urandom_range(0, 99) < pct) begin
                    ri = prog[ii];
                    if ($urandom_range(0, 149) == 0) begin
                        case ($urandom_range(0, 3))
                            0: ri.pc   = ri.pc ^ 32'h4;
                            1: ri.data = ri.data ^ 32'h1;
                            2: ri.we   = ~ri.we;
                            default: if (ri.rd >= 5'd2) ri.rd = ri.rd ^ 5'd1;
                        endcase
                    end
                    iv = 1'b1;
                    drive_isa(ri);
                    ii++;
                end
                step();
                model_cycle(v, fl, r0, r1, iv, ri);
            end
        end

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
